down_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 12 +
 rtl/down_counter.sv | 69 ++++++
 tb/tb_down_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Types and constants shared by the loadable up- and down-counters.
package counter_pkg;

   localparam int COUNTER_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter/timer: loads a start value, decrements on en, stops at zero with a tc pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the last loaded value instead of stopping.
module down_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic             tc_reg, tc_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         q_reg      <= '0;
         reload_reg <= '0;
         tc_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         q_reg      <= q_next;
         reload_reg <= reload_next;
         tc_reg     <= tc_next;
      end
   end

   // RUN is only entered with a non-zero count, so the decrement never wraps.
   always_comb begin
      state_next  = state_reg;
      q_next      = q_reg;
      reload_next = reload_reg;
      tc_next     = 1'b0;
      if (load) begin
         q_next      = d;
         reload_next = d;
         state_next  = (d != '0) ? RUN : IDLE;
      end else if (en && (state_reg == RUN)) begin
         if (q_reg > WIDTH'(1)) begin
            q_next = q_reg - WIDTH'(1);
         end else begin
            tc_next = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            q_next     = reload_reg;
            state_next = RUN;
`else
            q_next     = '0;
            state_next = DONE;
`endif
         end
      end
   end

   assign q    = q_reg;
   assign tc   = tc_reg;
   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: per-cycle reference model plus directed literal checks.
module tb_down_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] d;
   logic         load;
   logic         en;
   logic [W-1:0] q;
   logic         busy;
   logic         tc;
   logic         done;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   down_counter #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .d(d), .load(load), .en(en),
      .q(q), .busy(busy), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining count and a mode (stopped / counting / finished).
   int  m_count  = 0;
   int  m_start  = 0;
   int  m_mode   = 0;   // 0 stopped-idle, 1 counting, 2 finished
   bit  m_pulse  = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_count = 0; m_start = 0; m_mode = 0; m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (load) begin
            m_count = int'(d);
            m_start = int'(d);
            m_mode  = (d == 0) ? 0 : 1;
         end else if (en && m_mode == 1) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_pulse = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
               m_count = m_start;
`else
               m_mode = 2;
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_q",    int'(q),    m_count);
         chk("model_busy", int'(busy), int'(m_mode == 1));
         chk("model_tc",   int'(tc),   int'(m_pulse));
         chk("model_done", int'(done), int'(m_mode == 2));
      end
   end

   // Apply inputs for one edge, then settle 2 time units past it.
   task automatic step(input bit l, input int dv, input bit e);
      load = l; d = W'(dv); en = e;
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string tag, input int eq, input bit etc, input bit ebusy, input bit edone);
      chk({tag, "_q"},    int'(q),    eq);
      chk({tag, "_tc"},   int'(tc),   int'(etc));
      chk({tag, "_busy"}, int'(busy), int'(ebusy));
      chk({tag, "_done"}, int'(done), int'(edone));
   endtask

   int gap_en [6]   = '{1, 0, 0, 1, 1, 1};
   int gap_q  [6]   = '{3, 3, 3, 2, 1, 0};

   initial begin
      reset_n = 1'b0; load = 1'b0; en = 1'b0; d = '0;
      #1;
      lit("reset", 0, 0, 0, 0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      cmp_on = 1'b1;
      step(0, 0, 1);
      lit("idle_en", 0, 0, 0, 0);

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
      // basic countdown from 3
      step(1, 3, 0);
      lit("cd_load", 3, 0, 1, 0);
      step(0, 0, 1); lit("cd_2", 2, 0, 1, 0);
      step(0, 0, 1); lit("cd_1", 1, 0, 1, 0);
      step(0, 0, 1); lit("cd_0", 0, 1, 0, 1);
      step(0, 0, 1); lit("cd_hold", 0, 0, 0, 1);

      // enable gaps from 4
      step(1, 4, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, gap_en[i] != 0);
         lit($sformatf("gap%0d", i), gap_q[i], i == 5, i != 5, i == 5);
      end

      // load out of DONE at maximum value, then count 1 directly
      step(1, 15, 1); lit("max_load", 15, 0, 1, 0);
      step(1, 1, 0);  lit("one_load", 1, 0, 1, 0);
      step(0, 0, 1);  lit("one_tc", 0, 1, 0, 1);
`else
      // auto-reload with start value 2: tc every second enabled cycle
      step(1, 2, 0);
      lit("ar_load", 2, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1);
         lit($sformatf("ar%0d", i), (i % 2 == 0) ? 1 : 2, i % 2 == 1, 1, 0);
      end
      step(1, 1, 0); lit("ar1_load", 1, 0, 1, 0);
      step(0, 0, 1); lit("ar1_a", 1, 1, 1, 0);
      step(0, 0, 1); lit("ar1_b", 1, 1, 1, 0);
`endif

      // load wins over the terminal step
      step(1, 3, 0);
      step(0, 0, 1);
      step(0, 0, 1); lit("pri_pre", 1, 0, 1, 0);
      step(1, 5, 1); lit("pri_load", 5, 0, 1, 0);
      step(0, 0, 0); lit("pri_hold", 5, 0, 1, 0);

      // zero load parks in IDLE
      step(1, 0, 1); lit("zero_load", 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1);
      lit("zero_en", 0, 0, 0, 0);

      // asynchronous reset mid-count
      step(1, 9, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      lit("mid_pre", 6, 0, 1, 0);
      reset_n = 1'b0;
      #1;
      lit("mid_rst", 0, 0, 0, 0);
      #1;
      reset_n = 1'b1;
      step(0, 0, 1); lit("mid_after1", 0, 0, 0, 0);
      step(0, 0, 1); lit("mid_after2", 0, 0, 0, 0);

      step(0, 0, 0);
      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
